// File: rtl/mix_block_out.sv
// mix_block_out: reads a block of WORDS memory words, each holding BYTES
// 6-bit MIX character codes, converts each code to ASCII and shifts the
// characters out on an 8N1 UART line (LSB first, idle high).
//
// Optional feature: define MIX_OUT_CRLF_EN to append CR LF after each block.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, addressin      one-cycle command pulse and block base address
//   request, addressout   memory read request and address
//   grant, in             memory accept strobe; data valid the cycle after
//   tx                    UART serial output
//   busy, done            transfer in progress / end-of-block pulse
module mix_block_out #(
  parameter int WORDS  = 24,
  parameter int BYTES  = 5,
  parameter int AW     = 12,
  parameter int CLKDIV = 104
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [AW-1:0]        addressin,
  output logic                 request,
  output logic [AW-1:0]        addressout,
  input  logic                 grant,
  input  logic [6*BYTES-1:0]   in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);
  localparam int WW  = 6 * BYTES;
  localparam int WCW = $clog2(WORDS + 1);
  localparam int DW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, SEND
`ifdef MIX_OUT_CRLF_EN
    , EOL
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [WCW-1:0]  fw_q, fw_d;      // words requested
  logic [WCW-1:0]  sw_q, sw_d;      // words fully handed to the UART
  logic            req_q, req_d;
  logic            rdv_q, rdv_d;    // read data arrives this cycle
  logic [WW-1:0]   buf_q [2];
  logic [WW-1:0]   buf_d [2];
  logic            wp_q, wp_d, rp_q, rp_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [9:0]      frame_q, frame_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic            act_q, act_d;
  logic            done_q, done_d;
`ifdef MIX_OUT_CRLF_EN
  logic [1:0]      eol_q, eol_d;
`endif

  logic            frame_end, free, load, pop;
  logic [7:0]      ld_char;
  logic [5:0]      code;
  logic [WW-1:0]   head;

  function automatic logic [7:0] mix_ascii(input logic [5:0] c);
    logic [7:0] r;
    r = 8'h3F;
    if (c == 6'd0)       r = 8'h20;
    else if (c <= 6'd9)  r = 8'h40 + {2'b00, c};
    else if (c == 6'd10) r = 8'h5E;
    else if (c <= 6'd19) r = 8'h3F + {2'b00, c};
    else if (c == 6'd20) r = 8'h5B;
    else if (c == 6'd21) r = 8'h5D;
    else if (c <= 6'd29) r = 8'h3D + {2'b00, c};
    else if (c <= 6'd39) r = 8'h12 + {2'b00, c};
    else begin
      case (c)
        6'd40: r = 8'h2E;  6'd41: r = 8'h2C;  6'd42: r = 8'h28;  6'd43: r = 8'h29;
        6'd44: r = 8'h2B;  6'd45: r = 8'h2D;  6'd46: r = 8'h2A;  6'd47: r = 8'h2F;
        6'd48: r = 8'h3D;  6'd49: r = 8'h24;  6'd50: r = 8'h3C;  6'd51: r = 8'h3E;
        6'd52: r = 8'h40;  6'd53: r = 8'h3B;  6'd54: r = 8'h3A;  6'd55: r = 8'h27;
        default: r = 8'h3F;
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      fw_q    <= '0;
      sw_q    <= '0;
      req_q   <= 1'b0;
      rdv_q   <= 1'b0;
      buf_q   <= '{default: '0};
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= '0;
      bidx_q  <= '0;
      frame_q <= '1;
      div_q   <= '0;
      bit_q   <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef MIX_OUT_CRLF_EN
      eol_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      fw_q    <= fw_d;
      sw_q    <= sw_d;
      req_q   <= req_d;
      rdv_q   <= rdv_d;
      buf_q   <= buf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      frame_q <= frame_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      act_q   <= act_d;
      done_q  <= done_d;
`ifdef MIX_OUT_CRLF_EN
      eol_q   <= eol_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    fw_d    = fw_q;
    sw_d    = sw_q;
    req_d   = req_q;
    rdv_d   = 1'b0;
    buf_d   = buf_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    bidx_d  = bidx_q;
    frame_d = frame_q;
    div_d   = div_q;
    bit_d   = bit_q;
    act_d   = act_q;
    done_d  = 1'b0;
`ifdef MIX_OUT_CRLF_EN
    eol_d   = eol_q;
`endif
    load    = 1'b0;
    pop     = 1'b0;
    ld_char = 8'h00;

    // The last cycle of a stop bit may load the next character directly,
    // so consecutive characters leave with no idle time between them.
    frame_end = act_q && (bit_q == 4'd9) && (div_q == DW'(CLKDIV - 1));
    free      = !act_q || frame_end;

    head = buf_q[rp_q];
    code = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (bidx_q == 3'(BYTES - 1 - i)) code = head[6*i +: 6];
    end

    if (act_q) begin
      if (div_q == DW'(CLKDIV - 1)) begin
        div_d = '0;
        if (bit_q == 4'd9) begin
          act_d   = 1'b0;
          frame_d = '1;
        end else begin
          bit_d   = bit_q + 4'd1;
          frame_d = {1'b1, frame_q[9:1]};
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    // Fetch engine: the word being sent stays at the buffer head until its
    // last character is loaded, so a request goes out whenever the buffered
    // plus in-flight words leave a slot free.
    if (req_q) begin
      if (grant) begin
        req_d = 1'b0;
        rdv_d = 1'b1;
        fw_d  = fw_q + WCW'(1);
      end
    end else if ((state_q == FETCH || state_q == WAIT || state_q == SEND) &&
                 (fw_q < WCW'(WORDS)) && ((cnt_q + 2'(rdv_q)) < 2'd2)) begin
      req_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          base_d  = addressin;
          fw_d    = '0;
          sw_d    = '0;
          bidx_d  = '0;
          req_d   = 1'b1;
        end
      end
      FETCH: if (req_q && grant) state_d = WAIT;
      WAIT:  if (rdv_q) state_d = SEND;
      SEND: begin
        if (free) begin
          if (cnt_q != 2'd0) begin
            load    = 1'b1;
            ld_char = mix_ascii(code);
            if (bidx_q == 3'(BYTES - 1)) begin
              pop    = 1'b1;
              bidx_d = '0;
              sw_d   = sw_q + WCW'(1);
            end else begin
              bidx_d = bidx_q + 3'd1;
            end
          end else if (sw_q == WCW'(WORDS)) begin
`ifdef MIX_OUT_CRLF_EN
            state_d = EOL;
            eol_d   = '0;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef MIX_OUT_CRLF_EN
      EOL: begin
        if (free) begin
          if (eol_q == 2'd0) begin
            load = 1'b1; ld_char = 8'h0D; eol_d = 2'd1;
          end else if (eol_q == 2'd1) begin
            load = 1'b1; ld_char = 8'h0A; eol_d = 2'd2;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (load) begin
      frame_d = {1'b1, ld_char, 1'b0};
      div_d   = '0;
      bit_d   = '0;
      act_d   = 1'b1;
    end

    if (rdv_q) begin
      buf_d[wp_q] = in;
      wp_d        = ~wp_q;
    end
    if (pop) rp_d = ~rp_q;
    cnt_d = cnt_q + 2'(rdv_q) - 2'(pop);
  end

  always_comb begin
    request    = req_q;
    addressout = base_q + AW'(fw_q);
    tx         = frame_q[0];
    busy       = (state_q != IDLE);
    done       = done_q;
  end
endmodule

// File: tb/tb_mix_block_out.sv
module tb_mix_block_out;
  localparam int WORDS = 3, BYTES = 5, AW = 12, CLKDIV = 4, WW = 30;
`ifdef MIX_OUT_CRLF_EN
  localparam int EOLN = 2;
`else
  localparam int EOLN = 0;
`endif
  localparam int NCH = WORDS * BYTES + EOLN;

  logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, grant = 1'b0;
  logic [AW-1:0] addressin = '0, addressout;
  logic [WW-1:0] in_data = '0;
  logic          request, tx, busy, done;

  int checks = 0, errors = 0;
  int cyc = 0, first_grant = -1, done_cnt = 0, hold_left = 0;
  logic [AW-1:0] hold_addr = '0, pend_addr = '0;
  logic          pend = 1'b0, mon_en = 1'b0;
  logic [WW-1:0] mem [0:4095];
  logic [7:0]    exp_chr[$];
  logic [AW-1:0] exp_addr[$];
  int            start_log[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mix_block_out #(.WORDS(WORDS), .BYTES(BYTES), .AW(AW), .CLKDIV(CLKDIV)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .addressin(addressin),
    .request(request), .addressout(addressout), .grant(grant), .in(in_data),
    .tx(tx), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] tbl(input logic [5:0] c);
    string s;
    s = " ABCDEFGHI^JKLMNOPQR[]STUVWXYZ0123456789.,()+-*/=$<>@;:'";
    if (c < 6'd56) return s[c];
    return 8'h3F;
  endfunction

  function automatic logic [WW-1:0] mk(input logic [5:0] a, b, c, d, e);
    return {a, b, c, d, e};
  endfunction

  task automatic push_block(input logic [AW-1:0] base);
    logic [WW-1:0] w;
    logic [AW-1:0] a;
    for (int i = 0; i < WORDS; i++) begin
      a = base + AW'(i);
      exp_addr.push_back(a);
      w = mem[a];
      for (int b = BYTES - 1; b >= 0; b--) exp_chr.push_back(tbl(w[6*b +: 6]));
    end
`ifdef MIX_OUT_CRLF_EN
    exp_chr.push_back(8'h0D);
    exp_chr.push_back(8'h0A);
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [AW-1:0] a);
    start = 1'b1; addressin = a;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (done !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done, 1);
  endtask

  // Memory model: grants a pending request unless a hold is active for that
  // address, and presents the data in the cycle after the grant.
  always @(negedge clk) begin
    logic [AW-1:0] ea;
    if (pend) begin
      in_data = mem[pend_addr];
      pend = 1'b0;
    end
    grant = 1'b0;
    if (reset_n && request === 1'b1) begin
      if (hold_left > 0 && addressout == hold_addr) begin
        hold_left--;
      end else begin
        grant = 1'b1;
        pend = 1'b1;
        pend_addr = addressout;
        ea = (exp_addr.size() != 0) ? exp_addr.pop_front() : 'x;
        chk("addr", 32'(addressout), 32'(ea));
        if (first_grant < 0) first_grant = cyc;
      end
    end
  end

  // UART receiver sampling each bit at its centre.
  int rx_cnt = 0;
  logic rx_on = 1'b0;
  logic [7:0] rx_b = '0;
  always @(negedge clk) begin
    int k;
    logic [7:0] ec;
    if (!mon_en) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
        start_log.push_back(cyc);
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CLKDIV == CLKDIV / 2) begin
        k = rx_cnt / CLKDIV;
        if (k >= 1 && k <= 8) rx_b[k-1] = tx;
        else if (k == 9) begin
          chk("stop_bit", 32'(tx), 1);
          ec = (exp_chr.size() != 0) ? exp_chr.pop_front() : 'x;
          chk("char", 32'(rx_b), 32'(ec));
          rx_on = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && done === 1'b1) begin
      done_cnt++;
      chk("done_busy", 32'(busy), 0);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    // Reset state
    tick(3);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_req", 32'(request), 0);
    chk("rst_done", 32'(done), 0);
    reset_n = 1'b1; mon_en = 1'b1;
    tick(2);

    // Block A: address wrap, table boundaries, ignored restart
    mem[4094] = 30'o0102030405;
    mem[4095] = mk(6'd60, 6'd0, 6'd30, 6'd39, 6'd56);
    mem[0]    = mk(6'd10, 6'd20, 6'd21, 6'd55, 6'd63);
    done_cnt = 0; first_grant = -1; start_log.delete();
    push_block(12'd4094);
    pulse_start(12'd4094);
    chk("A_busy", 32'(busy), 1);
    tick(100);
    pulse_start(12'd500);
    chk("A_busy_after_restart", 32'(busy), 1);
    wait_done("A_done", 2000);
    tick(2);
    chk("A_done_cnt", 32'(done_cnt), 1);
    chk("A_done_low", 32'(done), 0);
    chk("A_chars_left", 32'(exp_chr.size()), 0);
    chk("A_addr_left", 32'(exp_addr.size()), 0);
    chk("A_nchars", 32'(start_log.size()), 32'(NCH));
    chk("A_latency", 32'((start_log[0] - first_grant) <= 3), 1);
    chk("A_b2b_w01", 32'(start_log[5] - start_log[4]), 40);
    chk("A_b2b_w12", 32'(start_log[10] - start_log[9]), 40);

    // Block B: grant withheld on word 2
    for (int i = 100; i < 103; i++) mem[i] = WW'($urandom);
    done_cnt = 0; first_grant = -1; start_log.delete();
    hold_addr = 12'd102; hold_left = 250;
    push_block(12'd100);
    pulse_start(12'd100);
    wait_done("B_done", 3000);
    tick(5);
    chk("B_done_cnt", 32'(done_cnt), 1);
    chk("B_chars_left", 32'(exp_chr.size()), 0);
    chk("B_nchars", 32'(start_log.size()), 32'(NCH));
    chk("B_b2b_w01", 32'(start_log[5] - start_log[4]), 40);
    chk("B_gap_w12", 32'((start_log[10] - start_log[9]) > 40), 1);

    // Block C: reset mid-character (with start in the same cycle), then a clean block
    for (int i = 200; i < 203; i++) mem[i] = WW'($urandom);
    for (int i = 300; i < 303; i++) mem[i] = WW'($urandom);
    done_cnt = 0; first_grant = -1; start_log.delete();
    push_block(12'd200);
    pulse_start(12'd200);
    n = 0;
    while (start_log.size() == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("C_first_char_seen", 32'(start_log.size()), 1);
    tick(15);
    mon_en = 1'b0; reset_n = 1'b0; start = 1'b1; addressin = 12'd700;
    @(negedge clk);
    start = 1'b0;
    chk("C_rst_tx", 32'(tx), 1);
    chk("C_rst_busy", 32'(busy), 0);
    chk("C_rst_req", 32'(request), 0);
    chk("C_rst_done", 32'(done), 0);
    exp_chr.delete(); exp_addr.delete();
    tick(2);
    reset_n = 1'b1; mon_en = 1'b1;
    tick(2);
    chk("C_idle_after_rst", 32'(busy), 0);
    done_cnt = 0; first_grant = -1; start_log.delete();
    push_block(12'd300);
    pulse_start(12'd300);
    wait_done("C_done", 2000);
    tick(2);
    chk("C_done_cnt", 32'(done_cnt), 1);
    chk("C_chars_left", 32'(exp_chr.size()), 0);
    chk("C_addr_left", 32'(exp_addr.size()), 0);
    chk("C_nchars", 32'(start_log.size()), 32'(NCH));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
